// File: rtl/snes_bus_pkg.sv
// Shared types and sizing helpers for the parametrised SNES bus change detector.
package snes_bus_pkg;

    localparam int DEF_WIDTH       = 8;
    localparam int DEF_SYNC_STAGES = 2;
    localparam int DEF_SETTLE      = 2;

    typedef enum logic [0:0] {
        ST_IDLE     = 1'b0,
        ST_SETTLING = 1'b1
    } state_e;

    // Ceiling log2, used to size the settle counter.
    function automatic int clog2(input int value);
        int result;
        result = 0;
        for (int i = 0; i < 31; i++) begin
            if ((32'sd1 <<< i) < value) begin
                result = i + 1;
            end
        end
        return result;
    endfunction

endpackage

// File: rtl/snes_bus_sync_n_chain.sv
// Multi-bit synchroniser flop chain; every stage clears to zero on reset.
module snes_sync_chain
    import snes_bus_pkg::*;
#(
    parameter int WIDTH       = DEF_WIDTH,
    parameter int SYNC_STAGES = DEF_SYNC_STAGES
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] d_i,
    output logic [WIDTH-1:0] q_o
);

    logic [WIDTH-1:0] stage_q [SYNC_STAGES];

    // Shift the raw bus one stage deeper on every clock.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < SYNC_STAGES; i++) begin
                stage_q[i] <= '0;
            end
        end else begin
            stage_q[0] <= d_i;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                stage_q[i] <= stage_q[i-1];
            end
        end
    end

    assign q_o = stage_q[SYNC_STAGES-1];

endmodule

// File: rtl/snes_bus_sync_n.sv
// Synchronise, settle-filter and publish the SNES bus with a one-cycle commit pulse.
// Optional address comparator enabled by defining SNES_BUS_SYNC_MATCH_EN.
module snes_bus_sync_n
    import snes_bus_pkg::*;
#(
    parameter int WIDTH       = DEF_WIDTH,
    parameter int SYNC_STAGES = DEF_SYNC_STAGES,
    parameter int SETTLE      = DEF_SETTLE
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] bus_in,
    output logic [WIDTH-1:0] bus_out,
    output logic             event_latch,
    output logic             same_val,
    output logic             busy
`ifdef SNES_BUS_SYNC_MATCH_EN
    ,
    input  logic [WIDTH-1:0] match_addr,
    input  logic [WIDTH-1:0] match_mask,
    output logic             match_hit
`endif
);

    localparam int CNT_W = clog2(SETTLE + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SETTLE - 1);

    if (WIDTH < 1 || WIDTH > 32) begin : g_bad_width
        $error("snes_bus_sync_n: WIDTH must be in 1..32");
    end
    if (SYNC_STAGES < 2) begin : g_bad_sync
        $error("snes_bus_sync_n: SYNC_STAGES must be at least 2");
    end
    if (SETTLE < 1 || SETTLE > 255) begin : g_bad_settle
        $error("snes_bus_sync_n: SETTLE must be in 1..255");
    end

    logic [WIDTH-1:0] s_last_s;
    logic [WIDTH-1:0] s_prev_q;
    logic             stable_s;
    logic             commit_s;
    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] bus_out_q, bus_out_d;
    logic             event_q, event_d;
    logic             same_q, same_d;
    logic             busy_q, busy_d;

    snes_sync_chain #(
        .WIDTH       (WIDTH),
        .SYNC_STAGES (SYNC_STAGES)
    ) u_chain (
        .clk   (clk),
        .rst_n (rst_n),
        .d_i   (bus_in),
        .q_o   (s_last_s)
    );

    assign stable_s = (s_last_s == s_prev_q);
    assign commit_s = (state_q == ST_SETTLING) && stable_s && (cnt_q == CNT_LAST);

    // State and settle counter registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next-state: any unstable sample while settling restarts the count.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            ST_IDLE: begin
                if (s_last_s != bus_out_q) begin
                    state_d = ST_SETTLING;
                    cnt_d   = '0;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_SETTLING: begin
                if (!stable_s) begin
                    cnt_d = '0;
                end else if (cnt_q == CNT_LAST) begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // Output next values; the commit uses the current synchronised sample.
    always_comb begin
        bus_out_d = bus_out_q;
        event_d   = 1'b0;
        same_d    = 1'b0;
        busy_d    = (state_d == ST_SETTLING);
        if (commit_s) begin
            bus_out_d = s_last_s;
            event_d   = 1'b1;
            same_d    = (s_last_s == bus_out_q);
        end else begin
            bus_out_d = bus_out_q;
        end
    end

    // Delayed sample and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s_prev_q  <= '0;
            bus_out_q <= '0;
            event_q   <= 1'b0;
            same_q    <= 1'b0;
            busy_q    <= 1'b0;
        end else begin
            s_prev_q  <= s_last_s;
            bus_out_q <= bus_out_d;
            event_q   <= event_d;
            same_q    <= same_d;
            busy_q    <= busy_d;
        end
    end

    assign bus_out     = bus_out_q;
    assign event_latch = event_q;
    assign same_val    = same_q;
    assign busy        = busy_q;

`ifdef SNES_BUS_SYNC_MATCH_EN
    logic match_q, match_d;

    // Compare fires only on a commit, independent of same_val.
    always_comb begin
        if (commit_s) begin
            match_d = ((s_last_s & match_mask) == (match_addr & match_mask));
        end else begin
            match_d = 1'b0;
        end
    end

    // Registered match pulse, aligned with event_latch.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            match_q <= 1'b0;
        end else begin
            match_q <= match_d;
        end
    end

    assign match_hit = match_q;
`endif

endmodule

// File: tb/tb_snes_bus_sync_n.sv
// Directed bench for snes_bus_sync_n: default, wide/deep and long-settle instances.
module tb_snes_bus_sync_n;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [7:0]  bus_a;
    logic [7:0]  bout_a;
    logic        ev_a, same_a, busy_a;
    logic [15:0] bus_b;
    logic [15:0] bout_b;
    logic        ev_b, same_b, busy_b;
    logic [7:0]  bus_c;
    logic [7:0]  bout_c;
    logic        ev_c, same_c, busy_c;
    logic [7:0]  maddr, mmask;
    logic        hit_a;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    snes_bus_sync_n dut_a (
        .clk(clk), .rst_n(rst_n), .bus_in(bus_a), .bus_out(bout_a),
        .event_latch(ev_a), .same_val(same_a), .busy(busy_a)
`ifdef SNES_BUS_SYNC_MATCH_EN
        , .match_addr(maddr), .match_mask(mmask), .match_hit(hit_a)
`endif
    );

    snes_bus_sync_n #(.WIDTH(16), .SYNC_STAGES(3), .SETTLE(1)) dut_b (
        .clk(clk), .rst_n(rst_n), .bus_in(bus_b), .bus_out(bout_b),
        .event_latch(ev_b), .same_val(same_b), .busy(busy_b)
`ifdef SNES_BUS_SYNC_MATCH_EN
        , .match_addr(16'h0000), .match_mask(16'h0000), .match_hit()
`endif
    );

    snes_bus_sync_n #(.WIDTH(8), .SYNC_STAGES(2), .SETTLE(4)) dut_c (
        .clk(clk), .rst_n(rst_n), .bus_in(bus_c), .bus_out(bout_c),
        .event_latch(ev_c), .same_val(same_c), .busy(busy_c)
`ifdef SNES_BUS_SYNC_MATCH_EN
        , .match_addr(8'h00), .match_mask(8'h00), .match_hit()
`endif
    );

`ifndef SNES_BUS_SYNC_MATCH_EN
    assign hit_a = 1'b0;
`endif

    typedef struct {
        logic [7:0] bus;
        logic [7:0] exp_out;
        logic       exp_ev;
        logic       exp_same;
        logic       exp_busy;
    } vec_t;

    vec_t vecs [14];

    task automatic chk(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s[%0d] got %0h expected %0h", name, idx, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        // 0x00 -> 0xA5 step, then a one-cycle 0x3C glitch that returns to 0xA5.
        vecs[0]  = '{8'hA5, 8'h00, 1'b0, 1'b0, 1'b0};
        vecs[1]  = '{8'hA5, 8'h00, 1'b0, 1'b0, 1'b0};
        vecs[2]  = '{8'hA5, 8'h00, 1'b0, 1'b0, 1'b1};
        vecs[3]  = '{8'hA5, 8'h00, 1'b0, 1'b0, 1'b1};
        vecs[4]  = '{8'hA5, 8'hA5, 1'b1, 1'b0, 1'b0};
        vecs[5]  = '{8'hA5, 8'hA5, 1'b0, 1'b0, 1'b0};
        vecs[6]  = '{8'hA5, 8'hA5, 1'b0, 1'b0, 1'b0};
        vecs[7]  = '{8'h3C, 8'hA5, 1'b0, 1'b0, 1'b0};
        vecs[8]  = '{8'hA5, 8'hA5, 1'b0, 1'b0, 1'b0};
        vecs[9]  = '{8'hA5, 8'hA5, 1'b0, 1'b0, 1'b1};
        vecs[10] = '{8'hA5, 8'hA5, 1'b0, 1'b0, 1'b1};
        vecs[11] = '{8'hA5, 8'hA5, 1'b0, 1'b0, 1'b1};
        vecs[12] = '{8'hA5, 8'hA5, 1'b1, 1'b1, 1'b0};
        vecs[13] = '{8'hA5, 8'hA5, 1'b0, 1'b0, 1'b0};

        rst_n = 1'b0;
        bus_a = 8'h00;
        bus_b = 16'h0000;
        bus_c = 8'h00;
        maddr = 8'hFC;
        mmask = 8'hFE;
        step();
        step();
        chk("rst_out", 0, 32'(bout_a), 32'h0);
        chk("rst_ev", 0, 32'(ev_a), 32'h0);
        chk("rst_same", 0, 32'(same_a), 32'h0);
        chk("rst_busy", 0, 32'(busy_a), 32'h0);
        chk("rst_hit", 0, 32'(hit_a), 32'h0);
        rst_n = 1'b1;

        for (int i = 0; i < 14; i++) begin
            bus_a = vecs[i].bus;
            step();
            chk("tbl_out", i, 32'(bout_a), 32'(vecs[i].exp_out));
            chk("tbl_ev", i, 32'(ev_a), 32'(vecs[i].exp_ev));
            chk("tbl_same", i, 32'(same_a), 32'(vecs[i].exp_same));
            chk("tbl_busy", i, 32'(busy_a), 32'(vecs[i].exp_busy));
        end

        // Reset one cycle after busy rises aborts the settle.
        bus_a = 8'h5A;
        step();
        step();
        step();
        chk("pre_rst_busy", 0, 32'(busy_a), 32'h1);
        step();
        chk("pre_rst_ev", 0, 32'(ev_a), 32'h0);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_out", 0, 32'(bout_a), 32'h0);
        chk("mid_rst_busy", 0, 32'(busy_a), 32'h0);
        chk("mid_rst_ev", 0, 32'(ev_a), 32'h0);
        chk("mid_rst_same", 0, 32'(same_a), 32'h0);
        step();
        chk("hold_rst_ev", 0, 32'(ev_a), 32'h0);
        rst_n = 1'b1;
        for (int k = 1; k <= 7; k++) begin
            step();
            chk("post_rst_ev", k, 32'(ev_a), 32'(k == 5));
            chk("post_rst_busy", k, 32'(busy_a), 32'(k == 3 || k == 4));
            chk("post_rst_out", k, 32'(bout_a), (k >= 5) ? 32'h5A : 32'h0);
        end

`ifdef SNES_BUS_SYNC_MATCH_EN
        bus_a = 8'hFD;
        for (int k = 1; k <= 6; k++) begin
            step();
            chk("match_ev", k, 32'(ev_a), 32'(k == 5));
            chk("match_hit", k, 32'(hit_a), 32'(k == 5));
        end
        bus_a = 8'hFB;
        for (int k = 1; k <= 6; k++) begin
            step();
            chk("nomatch_ev", k, 32'(ev_a), 32'(k == 5));
            chk("nomatch_hit", k, 32'(hit_a), 32'h0);
        end
`endif

        // Wide, deep chain with SETTLE=1.
        bus_b = 16'hFFFC;
        for (int k = 1; k <= 7; k++) begin
            step();
            chk("w16_ev", k, 32'(ev_b), 32'(k == 5));
            chk("w16_busy", k, 32'(busy_b), 32'(k == 4));
            chk("w16_out", k, 32'(bout_b), (k >= 5) ? 32'hFFFC : 32'h0);
            if (k == 5) begin
                chk("w16_same", k, 32'(same_b), 32'h0);
            end
        end

        // SETTLE=4: a bus that keeps changing never commits.
        for (int i = 0; i < 10; i++) begin
            bus_c = 8'(i + 1);
            for (int j = 0; j < 2; j++) begin
                step();
                chk("tog_ev", 2 * i + j, 32'(ev_c), 32'h0);
            end
        end
        chk("tog_busy", 0, 32'(busy_c), 32'h1);
        chk("tog_out", 0, 32'(bout_c), 32'h0);
        bus_c = 8'h7E;
        for (int k = 1; k <= 8; k++) begin
            step();
            chk("hold_ev", k, 32'(ev_c), 32'(k == 7));
            chk("hold_busy", k, 32'(busy_c), 32'(k < 7));
            chk("hold_out", k, 32'(bout_c), (k >= 7) ? 32'h7E : 32'h0);
            if (k == 7) begin
                chk("hold_same", k, 32'(same_c), 32'h0);
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
